bit_serial_processor: RTL
=========================

Name: bit_serial_processor

Overview:
Parametrised successor to the 13-bit, 2-in/7-out one-bit processor. It is a single-accumulator, bit-addressed processor with generic input, output and internal register counts and a generic instruction-memory depth. The program is loaded serially, MSB first, while en=1, and runs at one instruction per cycle once en falls. New capabilities: a program length register, so the PC wraps at the loaded length, a load-overflow flag, and a constant-zero address for unconditional branches.

Parameters:
IN_REGS, 2, number of external input bits
OUT_REGS, 7, number of output register bits
INT_REGS, 4, number of internal scratch bits
IMEM_DEPTH, 16, number of instruction words (power of two, at least 2)
Derived (localparam, not overridable):
- AW = clog2(1+IN_REGS+OUT_REGS+INT_REGS)
- PCW = clog2(IMEM_DEPTH)
- BW = max(AW, PCW)
- IW = 3+AW+BW. Defaults give AW=4, BW=4, IW=11.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  1 = load mode, 0 = run mode
prog_in  in  1  serial program bit, sampled each clk while en=1
in_regs  in  IN_REGS  external input bits
out_regs  out  OUT_REGS  output register bits
pc  out  PCW  program counter
prog_len  out  PCW+1  number of complete words loaded
load_ovf  out  1  sticky flag: a word arrived with the memory full

Behaviour:
Reset (reset=0, async) clears all state to 0:
- out_regs, internal bits, acc, pc, prog_len, load_ovf
- shift register, bit counter, load pointer, mode register
- every imem word
Address map (bit[a]):
- 0 = constant 0 (reads 0, writes ignored)
- 1..IN_REGS = in_regs (read-only, writes ignored)
- next OUT_REGS addresses = out_regs
- next INT_REGS addresses = internal bits
- unused addresses read 0, writes ignored
Instruction format {op[2:0], a[AW-1:0], b[BW-1:0]}:
- 000 NOP
- 001 LD: acc=bit[a]
- 010 LDN: acc=~bit[a]
- 011 AND: acc&=bit[a]
- 100 OR: acc|=bit[a]
- 101 XOR: acc^=bit[a]
- 110 ST: bit[b]=acc
- 111 BRZ: if bit[a]==0 then pc=b[PCW-1:0], else pc+1
Load mode:
- Rising edge of en (mode reg 0 to 1) in that cycle: load pointer=0, prog_len=0, load_ovf=0, bit counter=0. The prog_in bit of that cycle is also shifted in.
- Each en=1 cycle shifts prog_in into the LSB of the shift register.
- On the IW-th bit: if the pointer is below IMEM_DEPTH, write the word to imem[pointer] and increment pointer and prog_len. Otherwise discard the word and set load_ovf. prog_len saturates at IMEM_DEPTH.
- Execution is frozen; out_regs and internal bits hold.
Run-mode entry:
- First cycle with en=0 after load: pc=0, partial shift discarded, no instruction executes.
- Execution starts on the following cycle.
Run mode:
- One instruction per cycle; in_regs are read in the executing cycle; writes visible next cycle.
- Non-branch: pc=pc+1, wrapping to 0 when pc==prog_len-1.
- BRZ target at or beyond prog_len: pc=0.
- prog_len==0: pc holds 0, nothing executes, outputs hold.
Reset mid-load or mid-run: immediate full clear as above. No partial word survives.

Optional Feature:
BIT_SERIAL_PROCESSOR_STEP_EN
- Defined: adds input port step (1 bit). In run mode an instruction executes only in cycles where step=1; otherwise pc and all state hold. Load behaviour is unchanged.
- Undefined: no step port; free-running execution as above.

Decomposition:
- Package bit_serial_processor_pkg holds:
  - opcode localparams OP_NOP..OP_BRZ
  - constant-zero address ADDR_ZERO=0
  - clog2/max helper functions used to derive AW, BW, IW
- Sub-module bit_serial_loader: shift register, bit counter, load pointer, prog_len and overflow logic. It outputs a write strobe, write address and write data. Execution core and register file stay in the top module.

Test Plan:
- Reset low for 2 cycles, then release -> out_regs=0, pc=0, prog_len=0, load_ovf=0, all 16 imem words = 0.
- en=1, 11 cycles of prog_in=1 then 11 cycles of 0 -> imem[0]=11'b11111111111, imem[1]=0, prog_len=2.
- Load LD a=1 (00100010000) then ST b=3 (11000000011); en=0; in_regs[0]=1 -> out_regs[0]=1 within 3 cycles; pc sequence 0,1,0,1; in_regs[0]=0 -> out_regs[0]=0 after 2 cycles.
- Load BRZ a=2 b=0 (11100100000), LD a=1, ST b=3; in_regs[1]=0 -> pc stays 0 and out_regs holds; in_regs[1]=1 -> out_regs[0] tracks in_regs[0].
- Load 17 words -> prog_len=16, load_ovf=1, imem[15] holds word 16, word 17 discarded; new en rising edge -> load_ovf=0.
- Drop reset after 5 bits of a word -> all state 0; after reset, a full 11-bit load lands in imem[0].

Source files
------------

// File: rtl/bit_serial_processor_pkg.sv
// Shared opcodes, address constants and the width helpers for the bit-serial processor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bit_serial_processor_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_LDN = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_ST  = 3'd6;
  localparam logic [2:0] OP_BRZ = 3'd7;

  // Address 0 always reads 0, so "BRZ 0, target" is an unconditional jump.
  localparam int ADDR_ZERO = 0;

  // Smallest r with 2**r >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/bit_serial_loader.sv
// Serial program loader: assembles MSB-first words from prog_in and emits imem writes.
// Latency: a word is written on the clock edge that samples its last bit.
// Backpressure: none; words arriving with the memory full are dropped and flagged.
// Ports: clk, reset (async active-low), en/prog_in (serial load stream),
//        mode (registered en), wr_en/wr_addr/wr_data (imem write), prog_len, load_ovf.
module bit_serial_loader
  import bit_serial_processor_pkg::*;
#(
  parameter int IW         = 11,
  parameter int IMEM_DEPTH = 16,
  parameter int PCW        = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           prog_in,
  output logic           mode,
  output logic           wr_en,
  output logic [PCW-1:0] wr_addr,
  output logic [IW-1:0]  wr_data,
  output logic [PCW:0]   prog_len,
  output logic           load_ovf
);

  localparam int             CW    = clog2(IW);
  localparam logic [CW-1:0]  LAST  = CW'(IW - 1);
  localparam logic [PCW:0]   DEPTH = (PCW + 1)'(IMEM_DEPTH);

  logic [IW-2:0] shift_q;
  logic [CW-1:0] cnt_q;
  logic [PCW:0]  len_q;    // doubles as the load pointer: both advance together
  logic          ovf_q;
  logic          mode_q;

  logic          start;
  logic          word_done;
  logic [CW-1:0] cnt_base;
  logic [PCW:0]  len_base;

  // On the first cycle of a load the counters restart, but that cycle's bit
  // is still consumed as bit 0 of the first word.
  always_comb begin
    start     = en & ~mode_q;
    cnt_base  = start ? '0 : cnt_q;
    len_base  = start ? '0 : len_q;
    word_done = en && (cnt_base == LAST);
    wr_en     = word_done && (len_base < DEPTH);
    wr_addr   = len_base[PCW-1:0];
    wr_data   = {shift_q, prog_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      mode_q <= en;
      if (en) begin
        shift_q <= {shift_q[IW-3:0], prog_in};
        cnt_q   <= word_done ? '0 : cnt_base + CW'(1);
        len_q   <= wr_en ? len_base + (PCW + 1)'(1) : len_base;
        ovf_q   <= (start ? 1'b0 : ovf_q) | (word_done & ~wr_en);
      end else begin
        // Leaving load mode throws away any partial word.
        cnt_q <= '0;
      end
    end
  end

  assign mode     = mode_q;
  assign prog_len = len_q;
  assign load_ovf = ovf_q;

endmodule

// File: rtl/bit_serial_processor.sv
// Single-accumulator bit-addressed processor with a serially loaded program memory.
// Latency: one instruction per cycle; stores visible the next cycle; first run cycle only resets pc.
// Backpressure: none; en=1 freezes execution while a program is shifted in.
// Ports: clk, reset (async active-low), en (1=load), prog_in, in_regs, out_regs, pc,
//        prog_len, load_ovf; optional step input when BIT_SERIAL_PROCESSOR_STEP_EN is defined.
module bit_serial_processor
  import bit_serial_processor_pkg::*;
#(
  parameter  int IN_REGS    = 2,
  parameter  int OUT_REGS   = 7,
  parameter  int INT_REGS   = 4,
  parameter  int IMEM_DEPTH = 16,
  localparam int AW         = clog2(1 + IN_REGS + OUT_REGS + INT_REGS),
  localparam int PCW        = clog2(IMEM_DEPTH),
  localparam int BW         = max2(AW, PCW),
  localparam int IW         = 3 + AW + BW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                prog_in,
`ifdef BIT_SERIAL_PROCESSOR_STEP_EN
  input  logic                step,
`endif
  input  logic [IN_REGS-1:0]  in_regs,
  output logic [OUT_REGS-1:0] out_regs,
  output logic [PCW-1:0]      pc,
  output logic [PCW:0]        prog_len,
  output logic                load_ovf
);

  localparam int IN_BASE  = ADDR_ZERO + 1;
  localparam int OUT_BASE = IN_BASE + IN_REGS;
  localparam int INT_BASE = OUT_BASE + OUT_REGS;

  logic [OUT_REGS-1:0] out_q;
  logic [INT_REGS-1:0] int_q;
  logic                acc_q;
  logic [PCW-1:0]      pc_q;
  logic [IW-1:0]       imem [IMEM_DEPTH];

  logic           mode;
  logic           wr_en;
  logic [PCW-1:0] wr_addr;
  logic [IW-1:0]  wr_data;

  bit_serial_loader #(
    .IW         (IW),
    .IMEM_DEPTH (IMEM_DEPTH),
    .PCW        (PCW)
  ) u_loader (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .prog_in  (prog_in),
    .mode     (mode),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .prog_len (prog_len),
    .load_ovf (load_ovf)
  );

  logic step_ok;
`ifdef BIT_SERIAL_PROCESSOR_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  logic run_entry;
  logic exec;
  assign run_entry = ~en & mode;
  assign exec      = ~en & ~mode & (prog_len != '0) & step_ok;

  logic [IW-1:0]  instr;
  logic [2:0]     op;
  logic [AW-1:0]  a;
  logic [BW-1:0]  b;
  logic           rd;
  logic [PCW-1:0] pc_seq;
  logic [PCW-1:0] tgt;
  logic [PCW-1:0] pc_next;

  always_comb begin
    instr = imem[pc_q];
    op    = instr[IW-1 -: 3];
    a     = instr[AW+BW-1 -: AW];
    b     = instr[BW-1:0];

    // Address 0 and unused addresses fall through to 0.
    rd = 1'b0;
    for (int i = 0; i < IN_REGS; i++)
      if (int'(a) == IN_BASE + i) rd = in_regs[i];
    for (int i = 0; i < OUT_REGS; i++)
      if (int'(a) == OUT_BASE + i) rd = out_q[i];
    for (int i = 0; i < INT_REGS; i++)
      if (int'(a) == INT_BASE + i) rd = int_q[i];

    // pc wraps at the loaded length, not at the memory depth.
    pc_seq  = ({1'b0, pc_q} == prog_len - (PCW + 1)'(1)) ? '0 : pc_q + PCW'(1);
    tgt     = b[PCW-1:0];
    pc_next = pc_seq;
    if (op == OP_BRZ && !rd)
      pc_next = ({1'b0, tgt} < prog_len) ? tgt : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= 1'b0;
      pc_q  <= '0;
      out_q <= '0;
      int_q <= '0;
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
    end else begin
      if (wr_en) imem[wr_addr] <= wr_data;
      if (run_entry) begin
        pc_q <= '0;
      end else if (exec) begin
        pc_q <= pc_next;
        case (op)
          OP_LD:  acc_q <= rd;
          OP_LDN: acc_q <= ~rd;
          OP_AND: acc_q <= acc_q & rd;
          OP_OR:  acc_q <= acc_q | rd;
          OP_XOR: acc_q <= acc_q ^ rd;
          OP_ST: begin
            for (int i = 0; i < OUT_REGS; i++)
              if (int'(b) == OUT_BASE + i) out_q[i] <= acc_q;
            for (int i = 0; i < INT_REGS; i++)
              if (int'(b) == INT_BASE + i) int_q[i] <= acc_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_regs = out_q;
  assign pc       = pc_q;

endmodule
